// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: state encoding, word byte-enable,
// request bundle and the request legality check.
package dm_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dm_req_t;

  // A single-byte enable must point at the byte the address selects; full words must be aligned.
  function automatic logic req_error(input logic [31:0] addr, input logic [3:0] be,
                                     input logic we, input int unsigned depth_log2);
    logic       err;
    logic       single;
    logic [1:0] low;
    err    = 1'b0;
    single = 1'b1;
    low    = 2'd0;
    case (be)
      4'b0001: low = 2'd0;
      4'b0010: low = 2'd1;
      4'b0100: low = 2'd2;
      4'b1000: low = 2'd3;
      default: single = 1'b0;
    endcase
    if (be == BE_WORD && addr[1:0] != 2'd0) err = 1'b1;
    if (single && addr[1:0] != low) err = 1'b1;
    if ((addr >> (depth_log2 + 2)) != 32'd0) err = 1'b1;
    if (we && be == 4'b0000) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/dm_array.sv
// Data word storage: synchronous bulk clear on reset, byte-enable write, combinational read.
module dm_array
  import dm_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            be,
  output logic [31:0]           rdata
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder for M-stage loads/stores: valid/ready accept, WAIT_CYCLES wait
// states, then a one-cycle registered response; busy lets the stall logic freeze F/D/E.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]  state;
  logic [3:0]  cnt;
  dm_req_t     lat;
  dm_req_t     live;
  dm_req_t     cur;
  logic        accept;
  logic        commit;
  logic        err;
  logic [31:0] rd_word;

  assign req_ready = reset && (state == IDLE);
  assign rsp_valid = reset && (state == RESP);
  assign busy      = reset && (state != IDLE);
  assign accept    = req_valid && req_ready;

  assign live = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

  // With zero wait states the commit edge is the accept edge, so the live request is used.
  assign cur    = (state == IDLE) ? live : lat;
  assign commit = (state == IDLE && accept && WAIT_CYCLES == 0) ||
                  (state == WAIT && cnt == 4'd1);
  assign err    = req_error(cur.addr, cur.be, cur.we, DEPTH_LOG2);

  dm_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (commit && cur.we && !err),
    .addr  (cur.addr[DEPTH_LOG2+1:2]),
    .wdata (cur.wdata),
    .be    (cur.be),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat   <= live;
            cnt   <= WAIT_INIT;
            state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        rsp_err   <= err;
        rsp_rdata <= (err || cur.we) ? 32'd0 : rd_word;
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder: one instance with two wait states and one
// with zero wait states for the back-to-back throughput case.
module tb_dm_responder;

  logic        clk;
  logic        reset;

  logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_err0, busy0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
  logic [3:0]  req_be0;

  logic        req_valid1, req_ready1, req_we1, rsp_valid1, rsp_err1, busy1;
  logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
  logic [3:0]  req_be1;

  int vectors;
  int miscompares;

  dm_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0)
  );

  dm_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request on dut0 from a negedge and returns the response plus the number of
  // cycles from the accept edge to the rsp_valid cycle; ends on the idle cycle after.
  task automatic access0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata, output logic err,
                         output int lat);
    int n;
    req_valid0 = 1'b1;
    req_we0    = we;
    req_addr0  = addr;
    req_wdata0 = wdata;
    req_be0    = be;
    n = 0;
    while (req_ready0 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid0 = 1'b0;
    lat = 1;
    while (rsp_valid0 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata0;
    err   = rsp_err0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready0 !== 1'b0 || rsp_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got ready=%b valid=%b busy=%b want 0/0/0",
               req_ready0, rsp_valid0, busy0);
    end
    vectors++;
    if (rsp_rdata0 !== 32'd0 || rsp_err0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_rsp: got rdata=%h err=%b want 0/0", rsp_rdata0, rsp_err0);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready0 !== 1'b1 || req_ready1 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release_ready: got %b/%b want 1/1", req_ready0, req_ready1);
    end
  endtask

  // Cycle-by-cycle timing of the first load: accept in cycle 1, response in cycle 4.
  task automatic test_first_load();
    req_valid0 = 1'b1;
    req_we0    = 1'b0;
    req_addr0  = 32'h0000_0010;
    req_wdata0 = 32'd0;
    req_be0    = 4'b1111;
    vectors++;
    if (req_ready0 !== 1'b1 || busy0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL c1_accept: got ready=%b busy=%b want 1/0", req_ready0, busy0);
    end
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      req_valid0 = 1'b0;
      vectors++;
      if (busy0 !== 1'b1 || rsp_valid0 !== 1'b0 || req_ready0 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL c%0d_wait: got busy=%b valid=%b ready=%b want 1/0/0",
                 c, busy0, rsp_valid0, req_ready0);
      end
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid0 !== 1'b1 || busy0 !== 1'b1 || rsp_rdata0 !== 32'd0 || rsp_err0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL c4_resp: got valid=%b busy=%b rdata=%h err=%b want 1/1/0/0",
               rsp_valid0, busy0, rsp_rdata0, rsp_err0);
    end
    @(negedge clk);
    vectors++;
    if (busy0 !== 1'b0 || rsp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL c5_idle: got busy=%b valid=%b ready=%b want 0/0/1",
               busy0, rsp_valid0, req_ready0);
    end
  endtask

  task automatic test_store_merge();
    logic [31:0] rd;
    logic        er;
    int          lat;
    access0(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b1111, rd, er, lat);
    vectors++;
    if (rd !== 32'd0 || er !== 1'b0 || lat != 3) begin
      miscompares++;
      $display("[TB] FAIL store_word: got rdata=%h err=%b lat=%0d want 0/0/3", rd, er, lat);
    end
    access0(1'b0, 32'h40, 32'd0, 4'b1111, rd, er, lat);
    vectors++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != 3) begin
      miscompares++;
      $display("[TB] FAIL load_word: got rdata=%h err=%b lat=%0d want deadbeef/0/3", rd, er, lat);
    end
    // Store data arrives replicated across lanes; only byte 1 may change.
    access0(1'b1, 32'h41, 32'hAAAA_AAAA, 4'b0010, rd, er, lat);
    vectors++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL store_byte1: got rdata=%h err=%b want 0/0", rd, er);
    end
    access0(1'b0, 32'h40, 32'd0, 4'b0001, rd, er, lat);
    vectors++;
    if (rd !== 32'hDEAD_AAEF || er !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_merged: got rdata=%h err=%b want deadaaef/0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    int          lat;
    access0(1'b0, 32'h42, 32'd0, 4'b1111, rd, er, lat);
    vectors++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL misaligned_word: got rdata=%h err=%b want 0/1", rd, er);
    end
    access0(1'b1, 32'h1000, 32'hCAFE_F00D, 4'b1111, rd, er, lat);
    vectors++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL out_of_range: got rdata=%h err=%b want 0/1", rd, er);
    end
    access0(1'b0, 32'h0, 32'd0, 4'b1111, rd, er, lat);
    vectors++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL word0_untouched: got rdata=%h err=%b want 0/0", rd, er);
    end
    access0(1'b1, 32'h44, 32'h1111_1111, 4'b0000, rd, er, lat);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL store_no_be: got err=%b want 1", er);
    end
    access0(1'b1, 32'h40, 32'h5555_5555, 4'b0010, rd, er, lat);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL byte_lane_mismatch: got err=%b want 1", er);
    end
    access0(1'b0, 32'h40, 32'd0, 4'b1111, rd, er, lat);
    vectors++;
    if (rd !== 32'hDEAD_AAEF || er !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL no_write_on_err: got rdata=%h err=%b want deadaaef/0", rd, er);
    end
  endtask

  // Zero wait states with req_valid held: one accept every two cycles.
  task automatic test_back_to_back();
    logic        t_we    [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_addr  [5] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h8};
    logic [31:0] t_wdata [5] = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0, 32'h0};
    logic [31:0] t_exp   [5] = '{32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222, 32'h0};
    int idx  = 0;
    int got  = 0;
    int cyc  = 0;
    int last = -1;
    req_valid1 = 1'b1;
    req_we1    = t_we[0];
    req_addr1  = t_addr[0];
    req_wdata1 = t_wdata[0];
    req_be1    = 4'b1111;
    while (got < 5 && cyc < 40) begin
      if (rsp_valid1 === 1'b1) begin
        vectors++;
        if (rsp_rdata1 !== t_exp[got] || rsp_err1 !== 1'b0 || req_ready1 !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL b2b_rsp%0d: got rdata=%h err=%b ready=%b want %h/0/0",
                   got, rsp_rdata1, rsp_err1, req_ready1, t_exp[got]);
        end
        got++;
      end
      if (req_ready1 === 1'b1 && idx < 5) begin
        if (last >= 0) begin
          vectors++;
          if (cyc - last != 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_gap%0d: got %0d cycles want 2", idx, cyc - last);
          end
        end
        last = cyc;
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx < 5) begin
        req_we1    = t_we[idx];
        req_addr1  = t_addr[idx];
        req_wdata1 = t_wdata[idx];
      end else begin
        req_valid1 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid1 = 1'b0;
    vectors++;
    if (got != 5 || idx != 5) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d accepts %0d responses want 5/5", idx, got);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    req_valid0 = 1'b1;
    req_we0    = 1'b1;
    req_addr0  = 32'h80;
    req_wdata0 = 32'h1234_5678;
    req_be0    = 4'b1111;
    n = 0;
    while (req_ready0 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid0 = 1'b0;
    vectors++;
    if (busy0 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_in_wait: got busy=%b want 1", busy0);
    end
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid0 !== 1'b0 || busy0 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL abort_held%0d: got valid=%b busy=%b want 0/0", c, rsp_valid0, busy0);
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid0 !== 1'b0 || busy0 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL abort_after%0d: got valid=%b busy=%b want 0/0", c, rsp_valid0, busy0);
      end
    end
    access0(1'b0, 32'h80, 32'd0, 4'b1111, rd, er, lat);
    vectors++;
    if (rd !== 32'd0 || er !== 1'b0 || lat != 3) begin
      miscompares++;
      $display("[TB] FAIL abort_discard: got rdata=%h err=%b lat=%0d want 0/0/3", rd, er, lat);
    end
  endtask

  task automatic test_idle();
    req_valid0 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0 || busy0 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle%0d: got ready=%b valid=%b busy=%b want 1/0/0",
                 c, req_ready0, rsp_valid0, busy0);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    req_valid0  = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0;
    req_valid1  = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = 4'b1111;
    test_reset();
    test_first_load();
    test_store_merge();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
